// File: rtl/shift_seq_core.sv
// rtl/shift_seq_core.sv - parametrised shift/rotate pattern sequencer with step prescaler
// Optional feature macro: SHIFT_AUTOWRAP_EN (reload SEED when SRL/SLL shifts the last one out)
module shift_seq_core #(
  parameter int              WIDTH = 8,
  parameter int              DIV   = 1,
  parameter logic [WIDTH-1:0] SEED = {1'b1, {(WIDTH-1){1'b0}}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             step,
  output logic             wrap,
  output logic             zero
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SRL  = 3'b001;
  localparam logic [2:0] M_SLL  = 3'b010;
  localparam logic [2:0] M_ROR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_SRA  = 3'b101;
  localparam logic [2:0] M_LOAD = 3'b110;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shifted;
  logic             is_shift;
  logic             wrap_hit;
  logic             terminal;

  // Next-pattern selection for the current mode, including the optional wrap reload
  always_comb begin
    shifted  = q;
    is_shift = 1'b1;
    wrap_hit = 1'b0;
    case (mode)
      M_SRL:   shifted = {ser_in, q[WIDTH-1:1]};
      M_SLL:   shifted = {q[WIDTH-2:0], ser_in};
      M_ROR:   shifted = {q[0], q[WIDTH-1:1]};
      M_ROL:   shifted = {q[WIDTH-2:0], q[WIDTH-1]};
      M_SRA:   shifted = {q[WIDTH-1], q[WIDTH-1:1]};
      default: is_shift = 1'b0;
    endcase
`ifdef SHIFT_AUTOWRAP_EN
    if ((mode == M_SRL || mode == M_SLL) && q != '0 && shifted == '0) begin
      shifted  = SEED;
      wrap_hit = 1'b1;
    end
`endif
    terminal = en && (cnt == CNT_MAX);
  end

  // Pattern register, prescaler and step pulse; LOAD overrides any pending step
  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= SEED;
      cnt  <= '0;
      step <= 1'b0;
    end else if (mode == M_LOAD) begin
      q    <= load_val;
      cnt  <= '0;
      step <= 1'b0;
    end else begin
      step <= 1'b0;
      if (en) begin
        cnt <= terminal ? '0 : cnt + 1'b1;
        if (terminal && is_shift) begin
          q    <= shifted;
          step <= 1'b1;
        end
      end
    end
  end

`ifdef SHIFT_AUTOWRAP_EN
  // Wrap pulse accompanies the step that reloaded SEED
  always_ff @(posedge clk) begin
    if (reset || mode == M_LOAD) begin
      wrap <= 1'b0;
    end else begin
      wrap <= terminal && is_shift && wrap_hit;
    end
  end
`else
  assign wrap = 1'b0;
`endif

  assign zero = (q == '0);

  // M_HOLD is documented for readability; the default case covers it
  logic unused_hold;
  assign unused_hold = (mode == M_HOLD) & wrap_hit;

endmodule

// File: tb/tb_shift_seq_core.sv
// tb/tb_shift_seq_core.sv - scoreboard bench for shift_seq_core at three width/prescale points
module tb_shift_seq_core;

  typedef struct packed {
    logic [11:0] q;
    logic        step;
    logic        wrap;
    logic        zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [2:0]  mode = 3'b000;
  logic        ser_in = 1'b0;
  logic [11:0] load_val = 12'h000;

  logic [7:0]  q0, q1;
  logic [11:0] q2;
  logic [2:0]  st, wr, zr;

  int n_cmp = 0;
  int n_err = 0;

  exp_t        sbq[$];
  logic [11:0] mq[3];
  int          mcnt[3];

  always #5 clk = ~clk;

  shift_seq_core #(.WIDTH(8), .DIV(1)) u0 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .ser_in(ser_in),
    .load_val(load_val[7:0]), .q(q0), .step(st[0]), .wrap(wr[0]), .zero(zr[0]));

  shift_seq_core #(.WIDTH(8), .DIV(3)) u1 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .ser_in(ser_in),
    .load_val(load_val[7:0]), .q(q1), .step(st[1]), .wrap(wr[1]), .zero(zr[1]));

  shift_seq_core #(.WIDTH(12), .DIV(4)) u2 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .ser_in(ser_in),
    .load_val(load_val), .q(q2), .step(st[2]), .wrap(wr[2]), .zero(zr[2]));

  function automatic int wid(input int i);
    return (i == 2) ? 12 : 8;
  endfunction

  function automatic int dv(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  function automatic logic [11:0] obs_q(input int i);
    return (i == 0) ? {4'h0, q0} : ((i == 1) ? {4'h0, q1} : q2);
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one clock edge of instance i, from the current inputs
  task automatic model_step(input int i, output exp_t e);
    int          w;
    logic [11:0] mask, seed, r, cur;
    logic        msb, stp, wrp;
    w    = wid(i);
    mask = 12'((1 << w) - 1);
    seed = 12'(1 << (w - 1));
    cur  = mq[i];
    msb  = cur[w-1];
    stp  = 1'b0;
    wrp  = 1'b0;
    if (reset) begin
      mq[i] = seed;
      mcnt[i] = 0;
    end else if (mode == 3'b110) begin
      mq[i] = load_val & mask;
      mcnt[i] = 0;
    end else if (en) begin
      if (mcnt[i] == dv(i) - 1) begin
        mcnt[i] = 0;
        case (mode)
          3'b001: r = (cur >> 1) | (ser_in ? seed : 12'h000);
          3'b010: r = ((cur << 1) | {11'h000, ser_in}) & mask;
          3'b011: r = (cur >> 1) | (cur[0] ? seed : 12'h000);
          3'b100: r = ((cur << 1) | {11'h000, msb}) & mask;
          3'b101: r = (cur >> 1) | (msb ? seed : 12'h000);
          default: r = cur;
        endcase
        if (mode >= 3'b001 && mode <= 3'b101) begin
          stp = 1'b1;
`ifdef SHIFT_AUTOWRAP_EN
          if ((mode == 3'b001 || mode == 3'b010) && cur != 12'h000 && r == 12'h000) begin
            r   = seed;
            wrp = 1'b1;
          end
`endif
          mq[i] = r;
        end
      end else begin
        mcnt[i] = mcnt[i] + 1;
      end
    end
    e.q    = mq[i];
    e.step = stp;
    e.wrap = wrp;
    e.zero = (mq[i] == 12'h000);
  endtask

  // One clock: push expectations for all instances, clock, then pop and compare
  task automatic cyc();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      model_step(i, e);
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      e = sbq.pop_front();
      chk($sformatf("u%0d.q", i), obs_q(i), e.q);
      chk($sformatf("u%0d.step", i), {11'h000, st[i]}, {11'h000, e.step});
      chk($sformatf("u%0d.wrap", i), {11'h000, wr[i]}, {11'h000, e.wrap});
      chk($sformatf("u%0d.zero", i), {11'h000, zr[i]}, {11'h000, e.zero});
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic [2:0] m,
                       input logic s, input logic [11:0] lv, input int n);
    reset = r; en = e; mode = m; ser_in = s; load_val = lv;
    for (int k = 0; k < n; k++) cyc();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      mq[i] = 12'h000;
      mcnt[i] = 0;
    end

    // Reset for two cycles
    drive(1'b1, 1'b0, 3'b000, 1'b0, 12'h000, 2);
    chk("reset.q0", {4'h0, q0}, 12'h080);
    chk("reset.q2", q2, 12'h800);

    // One-hot walk on the DIV=1 instance
    drive(1'b0, 1'b1, 3'b001, 1'b0, 12'h000, 7);
    chk("walk.q0_01", {4'h0, q0}, 12'h001);
    drive(1'b0, 1'b1, 3'b001, 1'b0, 12'h000, 1);
`ifdef SHIFT_AUTOWRAP_EN
    chk("walk.q0_wrap", {4'h0, q0}, 12'h080);
`else
    chk("walk.q0_zero", {4'h0, q0}, 12'h000);
`endif
    drive(1'b0, 1'b1, 3'b001, 1'b0, 12'h000, 1);

    // Prescaler with ROL on the DIV=3 instance
    drive(1'b0, 1'b1, 3'b110, 1'b0, 12'h081, 1);
    drive(1'b0, 1'b1, 3'b100, 1'b0, 12'h000, 3);
    chk("pre.q1_03", {4'h0, q1}, 12'h003);
    drive(1'b0, 1'b1, 3'b100, 1'b0, 12'h000, 3);
    chk("pre.q1_06", {4'h0, q1}, 12'h006);
    drive(1'b0, 1'b1, 3'b100, 1'b0, 12'h000, 1);
    drive(1'b0, 1'b0, 3'b100, 1'b0, 12'h000, 2);
    drive(1'b0, 1'b1, 3'b100, 1'b0, 12'h000, 1);

    // LOAD coinciding with terminal count on u1, then SRA steps
    drive(1'b0, 1'b1, 3'b110, 1'b0, 12'h0A5, 1);
    chk("load.q1", {4'h0, q1}, 12'h0A5);
    drive(1'b0, 1'b1, 3'b101, 1'b0, 12'h000, 1);
    chk("sra.q0_d2", {4'h0, q0}, 12'h0D2);
    drive(1'b0, 1'b1, 3'b101, 1'b0, 12'h000, 1);
    chk("sra.q0_e9", {4'h0, q0}, 12'h0E9);

    // Shifting the last one out of u0
    drive(1'b0, 1'b1, 3'b110, 1'b0, 12'h001, 1);
    drive(1'b0, 1'b1, 3'b001, 1'b0, 12'h000, 2);
    drive(1'b0, 1'b1, 3'b001, 1'b1, 12'h000, 1);
`ifdef SHIFT_AUTOWRAP_EN
    chk("nowrap.q0", {4'h0, q0}, 12'h0A0);
`else
    chk("nowrap.q0", {4'h0, q0}, 12'h080);
`endif

    // Reset mid-count on the WIDTH=12 DIV=4 instance
    drive(1'b0, 1'b1, 3'b110, 1'b0, 12'h001, 1);
    drive(1'b0, 1'b1, 3'b011, 1'b0, 12'h000, 2);
    drive(1'b1, 1'b1, 3'b011, 1'b0, 12'h000, 1);
    chk("rst.q2", q2, 12'h800);
    drive(1'b0, 1'b1, 3'b011, 1'b0, 12'h000, 3);
    chk("rst.q2_hold", q2, 12'h800);
    drive(1'b0, 1'b1, 3'b011, 1'b0, 12'h000, 1);
    chk("rst.q2_400", q2, 12'h400);

    // Random mix of modes, enables and occasional resets
    for (int k = 0; k < 80; k++) begin
      drive(($urandom_range(0, 24) == 0), 1'($urandom_range(0, 3) != 0),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            12'($urandom_range(0, 4095)), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
